// File: rtl/drac_reset_sequencer.sv
// drac_reset_sequencer
//   Tile-level reset/wake-up sequencer for NumHarts cores sharing one L1.5 port.
//   After the tile reset is released it waits WakeCycles edges, releases hart 0,
//   and then releases each further hart StaggerCycles edges after the previous one.
//   Once every hart is up, each hart can take a timed soft reset, which ends with
//   a one-cycle acknowledge.
//
// Ports
//   clk_i           tile clock
//   rst_i           asynchronous active-high reset
//   soft_rst_req_i  per-hart soft reset request, sampled on every edge
//   core_rstn_o     per-hart hard reset, active low (top_tile rstn_i)
//   soft_rstn_o     per-hart soft reset, active low (top_tile soft_rstn_i)
//   soft_ack_o      per-hart one-cycle pulse when a soft reset completes
//   grst_l_o        registered ~rst_i, global reset copy
//   all_up_o        every hart released, FSM in RUN
//   state_o         current FSM state (00 WAKE, 01 STAGGER, 10 RUN)
//
// state   | meaning
// --------+-------------------------------------------------------------
// WAKE    | counting wake-up edges; every hart held in reset
// STAGGER | releasing harts 1..NumHarts-1, one every StaggerCycles edges
// RUN     | all harts up; per-hart soft reset accepted; left only by rst_i

module drac_reset_sequencer #(
   parameter int NumHarts      = 1,
   parameter int WakeCycles    = 32768,
   parameter int StaggerCycles = 16,
   parameter int SoftRstCycles = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumHarts-1:0] soft_rst_req_i,
   output logic [NumHarts-1:0] core_rstn_o,
   output logic [NumHarts-1:0] soft_rstn_o,
   output logic [NumHarts-1:0] soft_ack_o,
   output logic                grst_l_o,
   output logic                all_up_o,
   output logic [1:0]          state_o
);

   localparam int MaxWS     = (WakeCycles > StaggerCycles) ? WakeCycles : StaggerCycles;
   localparam int MaxCycles = (MaxWS > SoftRstCycles) ? MaxWS : SoftRstCycles;
   localparam int CntW      = $clog2(MaxCycles + 1);
   localparam int IdxW      = (NumHarts > 1) ? $clog2(NumHarts) : 1;

   typedef enum logic [1:0] {
      ST_WAKE    = 2'b00,
      ST_STAGGER = 2'b01,
      ST_RUN     = 2'b10
   } state_t;

   state_t                state;
   logic [CntW-1:0]       wake_cnt;
   logic [CntW-1:0]       stag_cnt;
   logic [IdxW-1:0]       hart_idx;
   logic [NumHarts-1:0]   soft_act;
   logic [CntW-1:0]       soft_cnt [NumHarts];

   assign state_o = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_WAKE;
         wake_cnt    <= '0;
         stag_cnt    <= '0;
         hart_idx    <= '0;
         soft_act    <= '0;
         core_rstn_o <= '0;
         soft_rstn_o <= '0;
         soft_ack_o  <= '0;
         grst_l_o    <= 1'b0;
         all_up_o    <= 1'b0;
         for (int h = 0; h < NumHarts; h++) begin
            soft_cnt[h] <= '0;
         end
      end else begin
         grst_l_o   <= 1'b1;
         soft_ack_o <= '0;
         case (state)
            ST_WAKE: begin
               wake_cnt <= wake_cnt + CntW'(1);
               if (wake_cnt == CntW'(WakeCycles - 1)) begin
                  core_rstn_o[0] <= 1'b1;
                  soft_rstn_o[0] <= 1'b1;
                  if (NumHarts == 1) begin
                     state    <= ST_RUN;
                     all_up_o <= 1'b1;
                  end else begin
                     state    <= ST_STAGGER;
                     hart_idx <= IdxW'(1);
                     stag_cnt <= '0;
                  end
               end
            end
            ST_STAGGER: begin
               if (stag_cnt == CntW'(StaggerCycles - 1)) begin
                  stag_cnt <= '0;
                  // Loop over harts rather than indexing by hart_idx so a
                  // single-hart build never forms an out-of-range select.
                  for (int h = 0; h < NumHarts; h++) begin
                     if (hart_idx == IdxW'(h)) begin
                        core_rstn_o[h] <= 1'b1;
                        soft_rstn_o[h] <= 1'b1;
                     end
                  end
                  if (hart_idx == IdxW'(NumHarts - 1)) begin
                     state    <= ST_RUN;
                     all_up_o <= 1'b1;
                  end else begin
                     hart_idx <= hart_idx + IdxW'(1);
                  end
               end else begin
                  stag_cnt <= stag_cnt + CntW'(1);
               end
            end
            ST_RUN: begin
               // Every hart is released here, so soft_rstn is just ~soft_act.
               for (int h = 0; h < NumHarts; h++) begin
                  if (soft_act[h]) begin
                     if (soft_cnt[h] == '0) begin
                        soft_act[h]    <= 1'b0;
                        soft_rstn_o[h] <= 1'b1;
                        soft_ack_o[h]  <= 1'b1;
                     end else begin
                        soft_cnt[h] <= soft_cnt[h] - CntW'(1);
                     end
                  end else if (soft_rst_req_i[h]) begin
                     soft_act[h]    <= 1'b1;
                     soft_cnt[h]    <= CntW'(SoftRstCycles - 1);
                     soft_rstn_o[h] <= 1'b0;
                  end
               end
            end
            default: begin
               state <= ST_WAKE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drac_reset_sequencer.sv
// Bench for drac_reset_sequencer: a 4-hart and a 1-hart instance share clock
// and reset. Expected outputs come from edge-count arithmetic (release edges,
// soft reset end edges) rather than from a state machine.

module tb_drac_reset_sequencer;

   localparam int WAKE = 16;
   localparam int STAG = 4;
   localparam int SOFT = 8;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [3:0] req4  = '0;
   logic [0:0] req1  = '0;

   logic [3:0] core4, soft4, ack4;
   logic       grst4, allup4;
   logic [1:0] state4;
   logic [0:0] core1, soft1, ack1;
   logic       grst1, allup1;
   logic [1:0] state1;

   int n_vec = 0;
   int n_err = 0;

   // model: edges since reset release, and per-hart soft reset end edge
   int e_cnt [2];
   int soft_end [2][4];

   always #5 clk_i = ~clk_i;

   drac_reset_sequencer #(
      .NumHarts(4), .WakeCycles(WAKE), .StaggerCycles(STAG), .SoftRstCycles(SOFT)
   ) dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .soft_rst_req_i(req4),
      .core_rstn_o(core4), .soft_rstn_o(soft4), .soft_ack_o(ack4),
      .grst_l_o(grst4), .all_up_o(allup4), .state_o(state4)
   );

   drac_reset_sequencer #(
      .NumHarts(1), .WakeCycles(WAKE), .StaggerCycles(STAG), .SoftRstCycles(SOFT)
   ) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .soft_rst_req_i(req1),
      .core_rstn_o(core1), .soft_rstn_o(soft1), .soft_ack_o(ack1),
      .grst_l_o(grst1), .all_up_o(allup1), .state_o(state1)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int nh(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int run_edge(input int i);
      return WAKE + (nh(i) - 1) * STAG;
   endfunction

   function automatic logic [3:0] exp_core(input int i);
      logic [3:0] v = '0;
      for (int h = 0; h < nh(i); h++) v[h] = (e_cnt[i] >= WAKE + h * STAG);
      return v;
   endfunction

   function automatic logic [3:0] exp_soft(input int i);
      logic [3:0] v = exp_core(i);
      for (int h = 0; h < nh(i); h++)
         if (e_cnt[i] >= soft_end[i][h] - SOFT && e_cnt[i] < soft_end[i][h]) v[h] = 1'b0;
      return v;
   endfunction

   function automatic logic [3:0] exp_ack(input int i);
      logic [3:0] v = '0;
      for (int h = 0; h < nh(i); h++) v[h] = (e_cnt[i] == soft_end[i][h]);
      return v;
   endfunction

   function automatic logic [1:0] exp_state(input int i);
      if (e_cnt[i] >= run_edge(i)) return 2'b10;
      if (e_cnt[i] >= WAKE)        return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         e_cnt[i] = 0;
         for (int h = 0; h < 4; h++) soft_end[i][h] = -1000;
      end
   endtask

   task automatic model_edge(input int i, input logic [3:0] r);
      int x;
      x = e_cnt[i] + 1;
      for (int h = 0; h < nh(i); h++) begin
         if (e_cnt[i] >= run_edge(i) && r[h] &&
             !(soft_end[i][h] - SOFT < x && x <= soft_end[i][h]))
            soft_end[i][h] = x + SOFT;
      end
      e_cnt[i] = x;
   endtask

   task automatic compare_all();
      logic [3:0] z;
      z = '0;
      if (rst_i) begin
         check_val("core4",  core4,  z);
         check_val("soft4",  soft4,  z);
         check_val("ack4",   ack4,   z);
         check_val("grst4",  grst4,  1'b0);
         check_val("allup4", allup4, 1'b0);
         check_val("state4", state4, 2'b00);
         check_val("core1",  core1,  1'b0);
         check_val("soft1",  soft1,  1'b0);
         check_val("state1", state1, 2'b00);
      end else begin
         check_val("core4",  core4,  exp_core(0));
         check_val("soft4",  soft4,  exp_soft(0));
         check_val("ack4",   ack4,   exp_ack(0));
         check_val("grst4",  grst4,  e_cnt[0] >= 1);
         check_val("allup4", allup4, e_cnt[0] >= run_edge(0));
         check_val("state4", state4, exp_state(0));
         check_val("core1",  core1,  exp_core(1) & 4'b0001);
         check_val("soft1",  soft1,  exp_soft(1) & 4'b0001);
         check_val("ack1",   ack1,   exp_ack(1) & 4'b0001);
         check_val("grst1",  grst1,  e_cnt[1] >= 1);
         check_val("allup1", allup1, e_cnt[1] >= run_edge(1));
         check_val("state1", state1, exp_state(1));
      end
   endtask

   task automatic step(input logic [3:0] r4, input logic r1);
      req4 = r4;
      req1 = r1;
      @(posedge clk_i);
      if (!rst_i) begin
         model_edge(0, r4);
         model_edge(1, {3'b000, r1});
      end
      #1;
      compare_all();
   endtask

   // Asserts reset between edges: outputs must clear without waiting for a clock.
   task automatic do_reset(input int hold);
      rst_i = 1'b1;
      model_reset();
      #1;
      compare_all();
      repeat (hold) step(4'b0000, 1'b0);
      rst_i = 1'b0;
   endtask

   initial begin
      model_reset();
      #2;
      compare_all();
      repeat (2) step(4'b0000, 1'b0);
      rst_i = 1'b0;

      // T1/T5: bring-up with random requests in WAKE/STAGGER, hart 3 held
      // for edges 22..26 and dropped at edge 27.
      for (int k = 1; k <= 32; k++) begin
         logic [3:0] r;
         r = 4'($urandom);
         if (k >= 22 && k <= 26) r[3] = 1'b1;
         if (k >= 27) r = '0;
         step(r, (k < 16) ? 1'($urandom) : 1'b0);
      end

      // T2: single-cycle request on hart 2.
      step(4'b0100, 1'b1);
      repeat (11) step(4'b0000, 1'b0);

      // T3: harts 0 and 3 together, hart 0 re-requested mid-pulse, then in the ack cycle.
      step(4'b1001, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0001, 1'b0);
      repeat (6) step(4'b0000, 1'b0);
      step(4'b0001, 1'b0);
      repeat (10) step(4'b0000, 1'b0);

      // T4: reset in STAGGER after edge 21, then a full restart.
      do_reset(2);
      repeat (21) step(4'b0000, 1'b0);
      do_reset(1);
      repeat (30) step(4'b0000, 1'b0);

      // Random traffic with occasional reset.
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 2));
         step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
              ($urandom_range(0, 4) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
